// File: rtl/adaptive_thresh_gen.sv
// Per-frame adaptive hysteresis thresholds: tracks the frame peak between sof/eof,
// then floors, optionally smooths and scales it into thresh_hi/thresh_lo.
module adaptive_thresh_gen #(
    parameter int DATA_W   = 20,
    parameter int FRAC_W   = 8,
    parameter int MIN_PEAK = 64,
    parameter int HI_INIT  = 200,
    parameter int LO_INIT  = 100,
    parameter int SMOOTH   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic              eof,
    input  logic              px_valid,
    input  logic [DATA_W-1:0] px_mag,
    input  logic [FRAC_W-1:0] hi_ratio,
    input  logic [FRAC_W-1:0] lo_ratio,
    output logic [DATA_W-1:0] peak_val,
    output logic [DATA_W-1:0] thresh_hi,
    output logic [DATA_W-1:0] thresh_lo,
    output logic              thresh_valid,
    output logic              busy,
    output logic              overrun
);
    localparam int P_W = DATA_W + FRAC_W;
    localparam logic [DATA_W-1:0] MIN_P = DATA_W'(MIN_PEAK);

    typedef enum logic [2:0] {IDLE, TRACK, PEAK, MULT, OUT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic              first_q, first_d;
    logic [FRAC_W-1:0] hr_q, hr_d, lr_q, lr_d;
    logic [P_W-1:0]    hi_p_q, hi_p_d, lo_p_q, lo_p_d;
    logic [DATA_W-1:0] thi_q, thi_d, tlo_q, tlo_d;
    logic              tv_q, tv_d;
    logic              ovr_q, ovr_d;

    logic [DATA_W-1:0] px_in, floored, eff;
    logic [DATA_W:0]   sum;
    logic [P_W-1:0]    lo_min;

    assign px_in   = px_valid ? px_mag : '0;
    assign floored = (run_max_q > MIN_P) ? run_max_q : MIN_P;
    assign sum     = {1'b0, peak_q} + {1'b0, floored};
    assign eff     = (SMOOTH != 0 && !first_q) ? sum[DATA_W:1] : floored;
    // Clamp lo to hi before the shift so a ratio inversion can never put lo above hi.
    assign lo_min  = (lo_p_q < hi_p_q) ? lo_p_q : hi_p_q;
    assign busy    = (state_q == PEAK) || (state_q == MULT) || (state_q == OUT);

    always_comb begin
        state_d   = state_q;
        run_max_d = run_max_q;
        peak_d    = peak_q;
        first_d   = first_q;
        hr_d      = hr_q;
        lr_d      = lr_q;
        hi_p_d    = hi_p_q;
        lo_p_d    = lo_p_q;
        thi_d     = thi_q;
        tlo_d     = tlo_q;
        tv_d      = 1'b0;
        ovr_d     = ovr_q;
        case (state_q)
            IDLE: if (sof && !eof) begin
                state_d   = TRACK;
                run_max_d = px_in;
            end
            TRACK: begin
                if (px_valid && px_mag > run_max_q) run_max_d = px_mag;
                if (eof) begin
                    state_d = PEAK;
                    hr_d    = hi_ratio;
                    lr_d    = lo_ratio;
                end else if (sof) begin
                    run_max_d = px_in;
                end
            end
            PEAK: begin
                peak_d  = eff;
                first_d = 1'b0;
                state_d = MULT;
            end
            MULT: begin
                hi_p_d  = P_W'(peak_q) * P_W'(hr_q);
                lo_p_d  = P_W'(peak_q) * P_W'(lr_q);
                state_d = OUT;
            end
            OUT: begin
                thi_d   = hi_p_q[P_W-1:FRAC_W];
                tlo_d   = lo_min[P_W-1:FRAC_W];
                tv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A sof while the pipeline drains is dropped, not queued.
        if (sof && busy) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_max_q <= '0;
            peak_q    <= '0;
            first_q   <= 1'b1;
            hr_q      <= '0;
            lr_q      <= '0;
            hi_p_q    <= '0;
            lo_p_q    <= '0;
            thi_q     <= DATA_W'(HI_INIT);
            tlo_q     <= DATA_W'(LO_INIT);
            tv_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_max_q <= run_max_d;
            peak_q    <= peak_d;
            first_q   <= first_d;
            hr_q      <= hr_d;
            lr_q      <= lr_d;
            hi_p_q    <= hi_p_d;
            lo_p_q    <= lo_p_d;
            thi_q     <= thi_d;
            tlo_q     <= tlo_d;
            tv_q      <= tv_d;
            ovr_q     <= ovr_d;
        end
    end

    assign peak_val     = peak_q;
    assign thresh_hi    = thi_q;
    assign thresh_lo    = tlo_q;
    assign thresh_valid = tv_q;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_adaptive_thresh_gen.sv
// Bench for adaptive_thresh_gen: a raw-peak and a smoothed instance share one
// stimulus stream; expectations come from a frame-level model of the threshold rules.
module tb_adaptive_thresh_gen;
    localparam int DW = 20;
    localparam int FW = 8;

    logic clk = 1'b0, rst_n = 1'b0, sof = 1'b0, eof = 1'b0, px_valid = 1'b0;
    logic [DW-1:0] px_mag = '0;
    logic [FW-1:0] hi_ratio = '0, lo_ratio = '0;
    logic [DW-1:0] peak0, thi0, tlo0, peak1, thi1, tlo1;
    logic tv0, busy0, ovr0, tv1, busy1, ovr1;

    int checks = 0, errors = 0;
    int unsigned p1 = 0;
    bit first1 = 1'b1;
    logic [DW-1:0] q_mag[$];
    bit q_vld[$];

    adaptive_thresh_gen #(.SMOOTH(0)) u0 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .eof(eof), .px_valid(px_valid), .px_mag(px_mag),
        .hi_ratio(hi_ratio), .lo_ratio(lo_ratio), .peak_val(peak0), .thresh_hi(thi0),
        .thresh_lo(tlo0), .thresh_valid(tv0), .busy(busy0), .overrun(ovr0));
    adaptive_thresh_gen #(.SMOOTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .eof(eof), .px_valid(px_valid), .px_mag(px_mag),
        .hi_ratio(hi_ratio), .lo_ratio(lo_ratio), .peak_val(peak1), .thresh_hi(thi1),
        .thresh_lo(tlo1), .thresh_valid(tv1), .busy(busy1), .overrun(ovr1));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned scale(input int unsigned p, input int unsigned r);
        return (p * r) >> FW;
    endfunction

    task automatic push(input int unsigned m, input bit v);
        q_mag.push_back(DW'(m));
        q_vld.push_back(v);
    endtask

    task automatic reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_hi0"}, thi0, 200);   chk({tag, "_lo0"}, tlo0, 100);
        chk({tag, "_pk0"}, peak0, 0);    chk({tag, "_tv0"}, tv0, 0);
        chk({tag, "_busy0"}, busy0, 0);  chk({tag, "_ovr0"}, ovr0, 0);
        chk({tag, "_hi1"}, thi1, 200);   chk({tag, "_pk1"}, peak1, 0);
        tick;
        tick;
        rst_n = 1'b1;
        p1 = 0;
        first1 = 1'b1;
        tick;
    endtask

    // Drives queued pixels as one frame (sof on the first beat, eof on the last)
    // and checks peak at E+1 and thresholds/valid pulse at E+3.
    task automatic run_frame(input string tag, input int unsigned hr, input int unsigned lr,
                             input bit sof_at_eof, input bit ovr_sof);
        int n = q_mag.size();
        int unsigned m = 0, f, e0, e1, lmin;
        for (int i = 0; i < n; i++) if (q_vld[i] && q_mag[i] > m) m = q_mag[i];
        f    = (m < 64) ? 64 : m;
        e0   = f;
        e1   = first1 ? f : (p1 + f) >> 1;
        lmin = (lr < hr) ? lr : hr;
        for (int i = 0; i < n; i++) begin
            sof      = (i == 0) || (sof_at_eof && i == n - 1);
            eof      = (i == n - 1);
            px_valid = q_vld[i];
            px_mag   = q_mag[i];
            hi_ratio = eof ? FW'(hr) : FW'($urandom);
            lo_ratio = eof ? FW'(lr) : FW'($urandom);
            tick;
        end
        sof = 1'b0; eof = 1'b0; px_valid = 1'b0;
        hi_ratio = FW'($urandom); lo_ratio = FW'($urandom);
        chk({tag, "_busy"}, busy0, 1);
        tick;
        chk({tag, "_peak0"}, peak0, e0);
        chk({tag, "_peak1"}, peak1, e1);
        chk({tag, "_tv_early"}, tv0, 0);
        if (ovr_sof) sof = 1'b1;
        tick;
        sof = 1'b0;
        tick;
        chk({tag, "_tv0"}, tv0, 1);       chk({tag, "_tv1"}, tv1, 1);
        chk({tag, "_hi0"}, thi0, scale(e0, hr));
        chk({tag, "_lo0"}, tlo0, scale(e0, lmin));
        chk({tag, "_hi1"}, thi1, scale(e1, hr));
        chk({tag, "_lo1"}, tlo1, scale(e1, lmin));
        tick;
        chk({tag, "_tv_off"}, tv0, 0);
        chk({tag, "_idle"}, busy0, 0);
        p1 = e1;
        first1 = 1'b0;
        q_mag.delete();
        q_vld.delete();
    endtask

    initial begin
        int unsigned last_hi;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        // Reset in the middle of a frame
        sof = 1'b1; px_valid = 1'b1; px_mag = 20'd5000;
        tick;
        sof = 1'b0;
        tick;
        reset_check("rst_mid");

        push(10, 1); push(500, 1); push(300, 1); push(1000, 1);
        run_frame("nominal", 179, 77, 0, 0);
        push(2000, 1); push(7, 1);
        run_frame("smooth2", 128, 64, 0, 0);
        push(20, 1); push(3, 1); push(15, 1);
        run_frame("floor", 179, 77, 0, 0);
        push(99999, 0); push(5, 0); push(123456, 0);
        run_frame("novalid", 179, 77, 0, 0);

        push(400, 1); push(12, 1);
        run_frame("ovr", 179, 77, 0, 1);
        chk("ovr_set0", ovr0, 1);
        chk("ovr_set1", ovr1, 1);
        last_hi = thi0;
        eof = 1'b1; px_valid = 1'b1; px_mag = 20'hFFFFF;
        tick;
        eof = 1'b0; px_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("no_extra_tv", tv0, 0);
            tick;
        end
        chk("hold_hi", thi0, last_hi);
        push(400, 1); push(100, 1);
        run_frame("after_ovr", 128, 64, 0, 0);
        chk("ovr_sticky", ovr0, 1);

        push(50, 1); push(700, 1); push(300, 1);
        run_frame("sof_eof", 179, 77, 1, 0);

        // Restart: a huge pixel in an abandoned frame must not leak into the next
        sof = 1'b1; px_valid = 1'b1; px_mag = 20'd900000;
        tick;
        sof = 1'b0;
        tick;
        push(100, 1); push(1500, 1);
        run_frame("restart", 179, 77, 0, 0);

        push(1000, 1); push(1, 1);
        run_frame("invert", 100, 200, 0, 0);

        for (int k = 0; k < 8; k++) begin
            int n = int'($urandom_range(2, 10));
            for (int i = 0; i < n; i++)
                push(($urandom % 4 == 0) ? $urandom % 100 : $urandom & 32'hFFFFF, 1'($urandom));
            run_frame($sformatf("rnd%0d", k), $urandom % 256, $urandom % 256, 1'($urandom), 0);
        end

        reset_check("rst2");
        push(300, 1); push(10, 1);
        run_frame("first_after_rst", 200, 50, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adaptive_thresh_gen.md
Name: adaptive_thresh_gen

Overview:
Per-frame adaptive hysteresis-threshold generator for the Canny stage.
- Tracks the peak gradient magnitude over each frame, delimited by sof/eof.
- At frame end, latches the peak, optionally smooths it across frames, applies a floor, and scales it by runtime ratios.
- Produces thresh_hi/thresh_lo for the hysteresis block, and holds them constant for the whole next frame.

Parameters:
DATA_W, 20, width of gradient magnitude, peak and thresholds
FRAC_W, 8, width of ratio inputs; a ratio is an unsigned fraction r/2^FRAC_W
MIN_PEAK, 64, floor applied to the effective peak before scaling
HI_INIT, 200, reset value of thresh_hi
LO_INIT, 100, reset value of thresh_lo
SMOOTH, 0, 0 = raw per-frame peak; 1 = two-frame average of the effective peak

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sof  in  1  start-of-frame pulse, one cycle
eof  in  1  end-of-frame pulse, one cycle
px_valid  in  1  px_mag valid this cycle
px_mag  in  DATA_W  gradient magnitude, unsigned
hi_ratio  in  FRAC_W  high-threshold ratio, sampled on the eof cycle
lo_ratio  in  FRAC_W  low-threshold ratio, sampled on the eof cycle
peak_val  out  DATA_W  effective peak of the last completed frame
thresh_hi  out  DATA_W  high threshold
thresh_lo  out  DATA_W  low threshold
thresh_valid  out  1  one-cycle pulse when thresholds update
busy  out  1  high in states PEAK/MULT/OUT
overrun  out  1  sticky; set when a sof is dropped

Behaviour:
- Reset (async assert, sync deassert upstream) forces these values:
  - state=IDLE, run_max=0, peak_val=0
  - thresh_hi=HI_INIT, thresh_lo=LO_INIT
  - thresh_valid=0, overrun=0, first_frame=1
  - Reset mid-frame discards the frame in progress.
- IDLE: on sof -> TRACK, with run_max <= (px_valid ? px_mag : 0). eof is ignored, and sof&eof in the same cycle is ignored.
- TRACK:
  - If px_valid && px_mag > run_max, then run_max <= px_mag (unsigned compare).
  - eof -> PEAK. A valid pixel on the eof cycle is included in the max. hi_ratio/lo_ratio are captured into registers on this cycle.
  - sof without eof: restart, with run_max reloaded exactly as in IDLE.
  - sof&eof in the same cycle: eof wins and sof is ignored.
- PEAK:
  - f = max(run_max, MIN_PEAK).
  - If SMOOTH=1 and first_frame=0: eff = (peak_val + f) >> 1, computed in DATA_W+1 bits, truncated.
  - Otherwise eff = f.
  - Update: peak_val <= eff, first_frame <= 0. Next state MULT.
- MULT:
  - hi_p = peak_val*hi_ratio and lo_p = peak_val*lo_ratio, each DATA_W+FRAC_W bits, registered.
  - Next state OUT.
- OUT:
  - thresh_hi <= hi_p >> FRAC_W. This always fits DATA_W, since ratio < 1.
  - thresh_lo <= min(lo_p, hi_p) >> FRAC_W, so lo never exceeds hi.
  - thresh_valid <= 1 for exactly one cycle. Next state IDLE.
- Latency: for eof sampled on edge E, peak_val updates at E+1, and thresholds plus thresh_valid update at E+3.
- sof arriving in PEAK/MULT/OUT:
  - The frame is dropped and overrun <= 1.
  - The block returns to IDLE normally and waits for the next sof.
- Outputs hold their value between updates. overrun clears only on reset.

Test Plan:
- Reset: assert rst_n=0 mid-TRACK -> immediately thresh_hi=200, thresh_lo=100, peak_val=0, valid=0, busy=0, state IDLE.
- Nominal frame (SMOOTH=0): sof, mags 10, 500, 300, then 1000 with eof; hi_ratio=179, lo_ratio=77 -> peak_val=1000 at E+1; thresh_hi=699, thresh_lo=300 and a one-cycle valid pulse at E+3.
- Floor: frame with peak 20 -> peak_val=64, thresh_hi=44, thresh_lo=19; a frame with no valid pixels also yields 64.
- Overrun and ordering:
  - sof during MULT -> overrun=1, no extra valid pulse; the following full frame with peak 400 and ratio 128/64 gives 200/100.
  - sof&eof in the same cycle in TRACK -> eof processed.
- Smoothing (SMOOTH=1):
  - Frame 1 peak 1000 -> eff 1000.
  - Frame 2 peak 2000 -> eff 1500; with hi_ratio=128, thresh_hi=750.
  - After reset, the first frame is unsmoothed.
- Ratio inversion: lo_ratio=200, hi_ratio=100, peak 1000 -> thresh_hi=thresh_lo=390. Ratios changed mid-frame take effect only as sampled at eof.
